// File: rtl/input_fetch_agu.sv
// input_fetch_agu: raster-order tile fetch from the Input SRAM into a 2-deep ready/valid stream.
//   Parameters: ADDR_W (SRAM word-address width), DATA_W (SRAM/stream data width).
//   Control: clk, rst (sync, active-high), start_i, abort_i, busy_o, done_o.
//   Tile config (latched on start): base_i, cols_i, rows_i, stride_i, pad_i.
//   SRAM: mem_cs_o, mem_oe_o, mem_addr_o, mem_w_req_o, mem_w_data_o, mem_r_data_i (1-cycle read latency).
//   Stream: data_o, valid_o, ready_i, last_o.
//   Optional feature macro: FETCH_ZERO_PAD_EN (zero-pad border of pad_i words around the tile).
`ifndef WRITE_DIS
`define WRITE_DIS 4'b1111
`endif

module input_fetch_agu #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [9:0]        cols_i,
    input  logic [9:0]        rows_i,
    input  logic [ADDR_W-1:0] stride_i,
    input  logic [1:0]        pad_i,
    output logic              mem_cs_o,
    output logic              mem_oe_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_w_req_o,
    output logic [DATA_W-1:0] mem_w_data_o,
    input  logic [DATA_W-1:0] mem_r_data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              last_o,
    output logic              busy_o,
    output logic              done_o
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
    state_t r_state, w_next;
    logic [ADDR_W-1:0] r_stride, r_row_ptr, w_stride, w_ptr, w_addr;
    logic [9:0] r_cols, r_rows, w_cols, w_rows;
    logic [10:0] r_col, r_row, w_col, w_row, w_ecols, w_erows;
    logic [1:0] r_cnt, w_wi;
    logic [DATA_W-1:0] r_q0, r_q1, w_cap;
    logic r_l0, r_l1, r_infl, r_infl_zero, r_infl_last;
    logic w_idle, w_go, w_empty, w_abort, w_pop, w_room, w_issue, w_row_end, w_last, w_int, w_adv;

    // In IDLE the first word is issued straight from the inputs so data reaches the stream two cycles after start.
    assign w_idle   = (r_state == IDLE);
    assign w_cols   = w_idle ? cols_i : r_cols;
    assign w_rows   = w_idle ? rows_i : r_rows;
    assign w_stride = w_idle ? stride_i : r_stride;
    assign w_ptr    = w_idle ? base_i : r_row_ptr;
    assign w_col    = w_idle ? 11'd0 : r_col;
    assign w_row    = w_idle ? 11'd0 : r_row;

`ifdef FETCH_ZERO_PAD_EN
    logic [1:0]  r_pad, w_pad;
    logic [10:0] w_pad11;
    assign w_pad   = w_idle ? pad_i : r_pad;
    assign w_pad11 = {9'd0, w_pad};
    assign w_ecols = {1'b0, w_cols} + {8'd0, w_pad, 1'b0};
    assign w_erows = {1'b0, w_rows} + {8'd0, w_pad, 1'b0};
    assign w_int   = (w_row >= w_pad11) && (w_row < w_pad11 + {1'b0, w_rows})
                  && (w_col >= w_pad11) && (w_col < w_pad11 + {1'b0, w_cols});
    assign w_addr  = w_ptr + ADDR_W'(w_col - w_pad11);
    // The row pointer tracks interior rows only, so it stays at base through the top border.
    assign w_adv   = (w_row >= w_pad11);
`else
    logic w_unused_pad;
    assign w_unused_pad = ^pad_i;
    assign w_ecols = {1'b0, w_cols};
    assign w_erows = {1'b0, w_rows};
    assign w_int   = 1'b1;
    assign w_addr  = w_ptr + ADDR_W'(w_col);
    assign w_adv   = 1'b1;
`endif

    assign w_empty   = (w_ecols == 11'd0) || (w_erows == 11'd0);
    assign w_go      = w_idle && start_i;
    assign w_abort   = abort_i && (r_state == FETCH || r_state == DRAIN);
    assign w_pop     = valid_o && ready_i;
    // A pop in this cycle frees a slot, which is what allows one word per cycle.
    assign w_room    = ({1'b0, r_cnt} + {2'd0, r_infl}) < (3'd2 + {2'd0, w_pop});
    assign w_issue   = w_room && ((w_go && !w_empty) || (r_state == FETCH && !abort_i));
    assign w_row_end = (w_col == w_ecols - 11'd1);
    assign w_last    = w_row_end && (w_row == w_erows - 11'd1);
    assign w_wi      = r_cnt - {1'b0, w_pop};
    assign w_cap     = r_infl_zero ? '0 : mem_r_data_i;

    assign mem_cs_o     = w_issue && w_int;
    assign mem_oe_o     = mem_cs_o;
    assign mem_addr_o   = mem_cs_o ? w_addr : '0;
    assign mem_w_req_o  = `WRITE_DIS;
    assign mem_w_data_o = '0;
    assign valid_o      = (r_cnt != 2'd0);
    assign data_o       = valid_o ? r_q0 : '0;
    assign last_o       = valid_o && r_l0;
    assign busy_o       = !w_idle;
    assign done_o       = (r_state == DONE);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = !w_go ? IDLE : w_empty ? DONE : w_last ? DRAIN : FETCH;
            FETCH:   w_next = abort_i ? IDLE : (w_issue && w_last) ? DRAIN : FETCH;
            DRAIN:   w_next = abort_i ? IDLE : (r_cnt == 2'd0 && !r_infl) ? DONE : DRAIN;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cols      <= '0;
            r_rows      <= '0;
            r_stride    <= '0;
            r_row_ptr   <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_cnt       <= '0;
            r_q0        <= '0;
            r_q1        <= '0;
            r_l0        <= 1'b0;
            r_l1        <= 1'b0;
            r_infl      <= 1'b0;
            r_infl_zero <= 1'b0;
            r_infl_last <= 1'b0;
`ifdef FETCH_ZERO_PAD_EN
            r_pad       <= '0;
`endif
        end else begin
            if (w_go) begin
                r_cols   <= cols_i;
                r_rows   <= rows_i;
                r_stride <= stride_i;
`ifdef FETCH_ZERO_PAD_EN
                r_pad    <= pad_i;
`endif
            end
            if (w_issue) begin
                r_col     <= w_row_end ? 11'd0 : w_col + 11'd1;
                r_row     <= w_row_end ? w_row + 11'd1 : w_row;
                r_row_ptr <= (w_row_end && w_adv) ? w_ptr + w_stride : w_ptr;
            end
            r_infl_zero <= !w_int;
            r_infl_last <= w_last;
            if (w_abort) begin
                r_infl <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_infl <= w_issue;
                r_cnt  <= r_cnt + {1'b0, r_infl} - {1'b0, w_pop};
                if (w_pop) begin
                    r_q0 <= r_q1;
                    r_l0 <= r_l1;
                end
                // Write slot is computed after the pop so a full FIFO that pops and captures keeps order.
                if (r_infl && w_wi == 2'd0) begin
                    r_q0 <= w_cap;
                    r_l0 <= r_infl_last;
                end
                if (r_infl && w_wi == 2'd1) begin
                    r_q1 <= w_cap;
                    r_l1 <= r_infl_last;
                end
            end
        end
    end
endmodule

// File: tb/tb_input_fetch_agu.sv
// tb_input_fetch_agu: randomized self-checking bench for input_fetch_agu against a raster-order tile model.
`ifndef WRITE_DIS
`define WRITE_DIS 4'b1111
`endif

module tb_input_fetch_agu;
    logic clk = 1'b0, rst = 1'b1, start_i = 1'b0, abort_i = 1'b0, ready_i = 1'b1;
    logic [17:0] base_i = '0, stride_i = '0, mem_addr_o;
    logic [9:0] cols_i = '0, rows_i = '0;
    logic [1:0] pad_i = '0;
    logic mem_cs_o, mem_oe_o, valid_o, last_o, busy_o, done_o;
    logic [3:0] mem_w_req_o;
    logic [31:0] mem_w_data_o, mem_r_data_i = '0, data_o;

    input_fetch_agu dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .base_i(base_i),
        .cols_i(cols_i), .rows_i(rows_i), .stride_i(stride_i), .pad_i(pad_i),
        .mem_cs_o(mem_cs_o), .mem_oe_o(mem_oe_o), .mem_addr_o(mem_addr_o),
        .mem_w_req_o(mem_w_req_o), .mem_w_data_o(mem_w_data_o), .mem_r_data_i(mem_r_data_i),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [17:0] a);
        return ({14'd0, a} * 32'h9E3779B1) ^ 32'h0137_5A5A;
    endfunction

    // 1-cycle SRAM; undriven cycles return noise so spurious captures show up.
    always @(posedge clk) mem_r_data_i <= (mem_cs_o && mem_oe_o) ? mem_f(mem_addr_o) : $urandom();

    int total = 0, bad = 0;
    int cyc, rmode = 0, issued, acc, done_cnt, done_cyc, first_v, last_acc, valid_cnt;
    int stall_err, ahead_err, oe_err;
    logic nx_start = 1'b0, nx_abort = 1'b0, prev_stall;
    logic [31:0] prev_data;
    logic [17:0] got_addr[$], exp_addr[$];
    logic [31:0] got_data[$], exp_data[$];
    bit got_last[$], exp_last[$];

    task automatic build_exp(input logic [17:0] base, input int cols, input int rows, input logic [17:0] stride, input int pad);
        int pe, ec, er;
        longint a;
        exp_addr.delete(); exp_data.delete(); exp_last.delete();
`ifdef FETCH_ZERO_PAD_EN
        pe = pad;
`else
        pe = 0;
`endif
        ec = cols + 2 * pe;
        er = rows + 2 * pe;
        if (ec == 0 || er == 0) return;
        for (int r = 0; r < er; r++)
            for (int c = 0; c < ec; c++) begin
                if (r >= pe && r < pe + rows && c >= pe && c < pe + cols) begin
                    a = (longint'(base) + longint'(r - pe) * longint'(stride) + longint'(c - pe)) & 64'h3FFFF;
                    exp_addr.push_back(18'(a));
                    exp_data.push_back(mem_f(18'(a)));
                end else exp_data.push_back(32'd0);
                exp_last.push_back(r == er - 1 && c == ec - 1);
            end
    endtask

    function automatic int diff_addr();
        int m = 0;
        if (got_addr.size() != exp_addr.size()) return -1;
        foreach (got_addr[i]) if (got_addr[i] !== exp_addr[i]) m++;
        return m;
    endfunction

    function automatic int diff_data();
        int m = 0;
        if (got_data.size() != exp_data.size()) return -1;
        foreach (got_data[i]) if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) m++;
        return m;
    endfunction

    task automatic clear_mon();
        got_addr.delete(); got_data.delete(); got_last.delete();
        cyc = 0; issued = 0; acc = 0; done_cnt = 0; done_cyc = -1; first_v = -1; last_acc = -1;
        valid_cnt = 0; stall_err = 0; ahead_err = 0; oe_err = 0; prev_stall = 1'b0; prev_data = '0;
    endtask

    task automatic step();
        @(negedge clk);
        start_i = nx_start;
        abort_i = nx_abort;
        ready_i = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 9) < 7);
        #1;
        if (mem_cs_o) begin
            got_addr.push_back(mem_addr_o);
            issued++;
        end
        if (mem_cs_o !== mem_oe_o) oe_err++;
        if (prev_stall && (!valid_o || data_o !== prev_data)) stall_err++;
        if (valid_o) begin
            valid_cnt++;
            if (first_v < 0) first_v = cyc;
        end
        if (valid_o && ready_i) begin
            got_data.push_back(data_o);
            got_last.push_back(last_o);
            acc++;
            last_acc = cyc;
        end
        if (issued - acc > 2) ahead_err++;
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_stall = valid_o && !ready_i;
        prev_data = data_o;
        cyc++;
    endtask

    task automatic run_tile(input logic [17:0] base, input int cols, input int rows, input logic [17:0] stride,
                            input int pad, input int rm, input int ign_at);
        clear_mon();
        build_exp(base, cols, rows, stride, pad);
        rmode = rm;
        base_i = base; cols_i = 10'(cols); rows_i = 10'(rows); stride_i = stride; pad_i = 2'(pad);
        nx_start = 1'b1;
        step();
        nx_start = 1'b0;
        for (int k = 0; k < 400 && done_cnt == 0; k++) begin
            if (cyc == ign_at) begin
                nx_start = 1'b1;
                base_i = 18'h2A000; cols_i = 10'd7; rows_i = 10'd3; stride_i = 18'd1;
            end
            step();
            nx_start = 1'b0;
        end
        total++;
        if (done_cnt == 0) begin
            bad++;
            $display("FAIL tile_timeout: done_o never seen, got %0d words want %0d", got_data.size(), exp_data.size());
        end
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({mem_cs_o, mem_oe_o, valid_o, last_o, busy_o, done_o} !== 6'd0) begin
            bad++;
            $display("FAIL reset_ctrl: cs/oe/valid/last/busy/done=%b want 000000",
                     {mem_cs_o, mem_oe_o, valid_o, last_o, busy_o, done_o});
        end
        total++;
        if (mem_addr_o !== 18'd0 || data_o !== 32'd0 || mem_w_data_o !== 32'd0) begin
            bad++;
            $display("FAIL reset_data: addr=%h data=%h wdata=%h want 0", mem_addr_o, data_o, mem_w_data_o);
        end
        total++;
        if (mem_w_req_o !== `WRITE_DIS) begin
            bad++;
            $display("FAIL reset_wreq: got %b want %b", mem_w_req_o, `WRITE_DIS);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_tile(18'h100, 4, 2, 18'd8, 0, 0, -1);
        total++;
        if (diff_addr() != 0) begin
            bad++;
            $display("FAIL basic_addr: got %0d reads (%0d bad) want %0d", got_addr.size(), diff_addr(), exp_addr.size());
        end
        total++;
        if (diff_data() != 0) begin
            bad++;
            $display("FAIL basic_data: got %0d words (%0d bad) want %0d", got_data.size(), diff_data(), exp_data.size());
        end
        total++;
        if (first_v !== 2 || last_acc !== 9) begin
            bad++;
            $display("FAIL basic_timing: first valid cycle %0d last accept %0d want 2 and 9", first_v, last_acc);
        end
        total++;
        if (done_cnt !== 1 || busy_o !== 1'b0 || oe_err !== 0) begin
            bad++;
            $display("FAIL basic_done: done pulses %0d busy %b oe errors %0d want 1 0 0", done_cnt, busy_o, oe_err);
        end
    endtask

    task automatic test_stall();
        run_tile(18'h100, 4, 2, 18'd8, 0, 1, -1);
        total++;
        if (diff_data() != 0 || diff_addr() != 0) begin
            bad++;
            $display("FAIL stall_data: data diff %0d addr diff %0d want 0 0", diff_data(), diff_addr());
        end
        total++;
        if (stall_err !== 0 || ahead_err !== 0 || done_cnt !== 1) begin
            bad++;
            $display("FAIL stall_flow: unstable %0d ahead %0d done %0d want 0 0 1", stall_err, ahead_err, done_cnt);
        end
    endtask

    task automatic test_wrap();
        run_tile(18'h3FFFE, 4, 1, 18'd5, 0, 0, -1);
        total++;
        if (diff_addr() != 0 || got_addr.size() != 4 || got_addr[2] !== 18'h00000) begin
            bad++;
            $display("FAIL wrap_addr: got %0d reads, diff %0d, want 3fffe 3ffff 00000 00001", got_addr.size(), diff_addr());
        end
        total++;
        if (diff_data() != 0) begin
            bad++;
            $display("FAIL wrap_data: diff %0d want 0", diff_data());
        end
    endtask

    task automatic test_zero();
        run_tile(18'h40, 0, 3, 18'd1, 0, 0, -1);
        total++;
        if (issued !== 0 || valid_cnt !== 0) begin
            bad++;
            $display("FAIL zero_access: reads %0d valid cycles %0d want 0 0", issued, valid_cnt);
        end
        total++;
        if (done_cnt !== 1 || done_cyc !== 1) begin
            bad++;
            $display("FAIL zero_done: pulses %0d at cycle %0d want 1 at 1", done_cnt, done_cyc);
        end
    endtask

    task automatic test_ignore_start();
        run_tile(18'h100, 4, 2, 18'd8, 0, 0, 3);
        total++;
        if (diff_addr() != 0 || diff_data() != 0 || done_cnt !== 1) begin
            bad++;
            $display("FAIL ignore_start: addr diff %0d data diff %0d done %0d want 0 0 1", diff_addr(), diff_data(), done_cnt);
        end
    endtask

    task automatic test_abort();
        clear_mon();
        rmode = 0;
        base_i = 18'h700; cols_i = 10'd4; rows_i = 10'd4; stride_i = 18'd16; pad_i = 2'd0;
        nx_start = 1'b1;
        step();
        nx_start = 1'b0;
        repeat (3) step();
        nx_abort = 1'b1;
        step();
        nx_abort = 1'b0;
        total++;
        if (got_data.size() !== 3) begin
            bad++;
            $display("FAIL abort_pos: words by abort cycle %0d want 3", got_data.size());
        end
        step();
        total++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: busy %b valid %b want 0 0", busy_o, valid_o);
        end
        repeat (6) step();
        total++;
        if (done_cnt !== 0 || valid_cnt !== 3) begin
            bad++;
            $display("FAIL abort_quiet: done %0d valid cycles %0d want 0 3", done_cnt, valid_cnt);
        end
        run_tile(18'h100, 4, 2, 18'd8, 0, 0, -1);
        total++;
        if (diff_addr() != 0 || diff_data() != 0 || done_cnt !== 1) begin
            bad++;
            $display("FAIL abort_restart: addr diff %0d data diff %0d done %0d want 0 0 1", diff_addr(), diff_data(), done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        rmode = 0;
        base_i = 18'h900; cols_i = 10'd5; rows_i = 10'd3; stride_i = 18'd9;
        nx_start = 1'b1;
        step();
        nx_start = 1'b0;
        repeat (3) step();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: busy %b valid %b want 0 0", busy_o, valid_o);
        end
        done_cnt = 0;
        repeat (8) step();
        total++;
        if (done_cnt !== 0) begin
            bad++;
            $display("FAIL reset_mid_done: done pulses %0d want 0", done_cnt);
        end
    endtask

    task automatic test_random();
        int nbad = 0;
        for (int t = 0; t < 25; t++) begin
            run_tile(18'($urandom()), $urandom_range(0, 5), $urandom_range(0, 4), 18'($urandom()),
                     $urandom_range(0, 3), 2, -1);
            total++;
            if (diff_addr() != 0 || diff_data() != 0 || stall_err != 0 || ahead_err != 0 || done_cnt != 1) begin
                bad++;
                nbad++;
                $display("FAIL random_%0d: addr diff %0d data diff %0d unstable %0d ahead %0d done %0d want 0 0 0 0 1",
                         t, diff_addr(), diff_data(), stall_err, ahead_err, done_cnt);
            end
        end
    endtask

`ifdef FETCH_ZERO_PAD_EN
    task automatic test_pad();
        run_tile(18'h50, 2, 2, 18'd16, 1, 0, -1);
        total++;
        if (got_data.size() !== 16 || got_addr.size() !== 4) begin
            bad++;
            $display("FAIL pad_count: words %0d reads %0d want 16 4", got_data.size(), got_addr.size());
        end
        total++;
        if (diff_addr() != 0 || diff_data() != 0) begin
            bad++;
            $display("FAIL pad_data: addr diff %0d data diff %0d want 0 0", diff_addr(), diff_data());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_zero();
        test_ignore_start();
        test_abort();
        test_reset_mid();
`ifdef FETCH_ZERO_PAD_EN
        test_pad();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
